if_fetch_unit: RTL and testbench

//  Fetch stage of the 5-stage ARM pipeline: owns the PC register and the IF/ID pipeline register.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_if_id_reg.sv | 42 ++++
 rtl/if_fetch_unit.sv | 88 ++++++++
 tb/tb_if_fetch_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline types and constants for the IF and ID stages.
// if_id_t is the IF/ID register layout that decode also consumes.
package if_fetch_unit_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic              valid;
  } if_id_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, and load beats hold.
// One edge of latency. Hold is the only stall mechanism; there is no ready handshake.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    if (bubble) begin
      q_d.pc    = '0;
      q_d.instr = BUBBLE_INSTR;
      q_d.valid = 1'b0;
    end else if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q.pc    <= '0;
      q_q.instr <= BUBBLE_INSTR;
      q_q.valid <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC register, next-PC select, IF/ID register and saturating fetch counter.
// IF/ID outputs come straight from flops, so freeze/branch/flush only act at the next edge.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = if_fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                freeze,
  input  logic                                branch_taken,
  input  logic [if_fetch_unit_pkg::WORD_W-1:0] branch_addr,
  input  logic                                flush,
  output logic [if_fetch_unit_pkg::WORD_W-1:0] imem_addr,
  input  logic [if_fetch_unit_pkg::WORD_W-1:0] imem_data,
  output logic [if_fetch_unit_pkg::WORD_W-1:0] if_id_pc,
  output logic [if_fetch_unit_pkg::WORD_W-1:0] if_id_instr,
  output logic                                if_id_valid,
  output logic [CNT_W-1:0]                    fetch_count
);

  import if_fetch_unit_pkg::*;

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] pc_plus4;
  logic [CNT_W-1:0]  fetch_count_q;
  logic [CNT_W-1:0]  fetch_count_d;
  logic              bubble;
  logic              load;
  if_id_t            if_id_d;
  if_id_t            if_id_q;

  // Wraps silently past the top of the address space.
  assign pc_plus4 = pc_q + 32'd4;
  assign bubble   = branch_taken | flush;
  assign load     = ~freeze;

  always_comb begin
    pc_d = pc_plus4;
    if (branch_taken) begin
      pc_d = word_align(branch_addr);
    end else if (freeze) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (!bubble && load && (fetch_count_q != {CNT_W{1'b1}})) begin
      fetch_count_d = fetch_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    if_id_d.pc    = pc_plus4;
    if_id_d.instr = imem_data;
    if_id_d.valid = 1'b1;
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .bubble(bubble),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: vector table for single-edge behaviour,
// hand sequences for async reset and counter saturation.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  int n_vec;
  int n_bad;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .flush       (flush),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded words 0..2; every other word is {2'b10, word_index}.
  always_comb begin
    case (imem_addr[31:2])
      30'd0:   imem_data = 32'hE3A0_0014;
      30'd1:   imem_data = 32'hE3A0_1A01;
      30'd2:   imem_data = 32'hE3A0_2103;
      default: imem_data = {2'b10, imem_addr[31:2]};
    endcase
  end

  typedef struct {
    logic        frz;
    logic        br;
    logic        fl;
    logic [31:0] baddr;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_vld;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                         input logic [31:0] e_instr, input logic e_vld, input logic [15:0] e_cnt);
    chk({tag, ".imem_addr"},   imem_addr,           e_addr);
    chk({tag, ".if_id_pc"},    if_id_pc,            e_pc);
    chk({tag, ".if_id_instr"}, if_id_instr,         e_instr);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e_vld});
    chk({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, e_cnt});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //           frz   br    fl    baddr         addr          pc            instr         vld   cnt
    vt[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h4,        32'hE3A00014, 1'b1, 16'd1};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h8,        32'hE3A01A01, 1'b1, 16'd2};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h8,        32'hE3A01A01, 1'b1, 16'd2};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h8,        32'hE3A01A01, 1'b1, 16'd2};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'hC,        32'hE3A02103, 1'b1, 16'd3};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h6,        32'h4,        32'h0,        32'h0,        1'b0, 16'd3};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h8,        32'hE3A01A01, 1'b1, 16'd4};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h4,        32'h4,        32'h0,        32'h0,        1'b0, 16'd4};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h8,        32'h0,        32'h0,        1'b0, 16'd4};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'hC,        32'hE3A02103, 1'b1, 16'd5};
    vt[10] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'hC,        32'h0,        32'h0,        1'b0, 16'd5};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       32'h10,       32'h80000003, 1'b1, 16'd6};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0, 16'd6};
    vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'hBFFFFFFF, 1'b1, 16'd7};
    vt[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h4,        32'hE3A00014, 1'b1, 16'd8};
    vt[15] = '{1'b0, 1'b1, 1'b1, 32'h10,       32'h10,       32'h0,        32'h0,        1'b0, 16'd8};

    rst_n        = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    flush        = 1'b0;
    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      freeze       = vt[i].frz;
      branch_taken = vt[i].br;
      flush        = vt[i].fl;
      branch_addr  = vt[i].baddr;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_pc, vt[i].e_instr,
              vt[i].e_vld, vt[i].e_cnt);
    end

    // Async reset between edges must take effect without a clock.
    freeze       = 1'b0;
    branch_taken = 1'b0;
    flush        = 1'b0;
    branch_addr  = 32'h0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up to the saturation point with free-running fetches.
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("cnt_fffe", {16'd0, fetch_count}, 32'h0000_FFFE);
    @(posedge clk);
    @(negedge clk);
    chk("cnt_ffff", {16'd0, fetch_count}, 32'h0000_FFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cnt_sat", {16'd0, fetch_count}, 32'h0000_FFFF);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("cnt_flush_keep", {16'd0, fetch_count}, 32'h0000_FFFF);
    chk("flush_vld", {31'd0, if_id_valid}, 32'd0);

    #2 rst_n = 1'b0;
    #1 chk_all("sat_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
